// File: rtl/two_of_five_sched.sv
// two_of_five_sched: round-robin front end that shares one serial 2-of-5 checker
// among NREQ requesters. A granted 5-bit codeword is shifted out LSB first, the
// checker verdict is sampled CHK_LAT cycles after the last bit, and a tagged
// response is returned. A saturating counter tracks failed frames.
//
// Ports:
//   clk, rstn         rising-edge clock; asynchronous active-low reset
//   req, code         per-requester level request and 5-bit codeword (code[5i+4:5i])
//   gnt               one-hot acceptance pulse; the winner's code is captured this cycle
//   ser_out, ser_sync serial bit to the checker; ser_sync marks bit 0 of a frame
//   chk_valid         checker verdict, 1 = exactly two ones
//   rsp_valid         one-cycle response pulse; rsp_id / rsp_ok hold until overwritten
//   err_cnt           count of failed responses, saturating at 16'hFFFF
//   busy              high whenever a frame is in flight
module two_of_five_sched #(
  parameter int NREQ    = 4,
  parameter int CHK_LAT = 1,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*5-1:0] code,
  output logic [NREQ-1:0]   gnt,
  output logic              ser_out,
  output logic              ser_sync,
  input  logic              chk_valid,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_ok,
  output logic [15:0]       err_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [4:0]     shreg;
  logic [2:0]     bit_idx;
  logic [1:0]     wait_cnt;
  logic           wait_last;
  logic [15:0]    err_nxt;

  logic [4:0]     code_arr [NREQ];
  logic           found;
  logic [IDW-1:0] win_id;
  logic [4:0]     win_code;
  logic [IDW:0]   sum;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      code_arr[i] = code[5*i +: 5];
    end
  end

  // Scan upward from the round-robin pointer with wrap; the first requester wins.
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    win_code = '0;
    sum      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      if (!found && req[sum[IDW-1:0]]) begin
        found    = 1'b1;
        win_id   = sum[IDW-1:0];
        win_code = code_arr[sum[IDW-1:0]];
      end
    end
  end

  assign wait_last = (wait_cnt == 2'(CHK_LAT - 1));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and frame outputs
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    ser_out   = 1'b0;
    ser_sync  = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        // gnt is gated by rstn so it can never pulse while reset is held
        if (found && rstn) begin
          gnt[win_id] = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        ser_out  = shreg[0];
        ser_sync = (bit_idx == 3'd0);
        if (bit_idx == 3'd4) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_last) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    err_nxt = err_cnt;
    if (state == RESP && !rsp_ok && err_cnt != 16'hFFFF) begin
      err_nxt = err_cnt + 16'd1;
    end
  end

  // Frame datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      wait_cnt <= '0;
      rsp_id   <= '0;
      rsp_ok   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      // err_cnt is reloaded every cycle (holding when nothing changes)
      err_cnt <= err_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            shreg    <= win_code;
            rsp_id   <= win_id;
            ptr      <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
            bit_idx  <= 3'd0;
            wait_cnt <= 2'd0;
          end
        end
        SHIFT: begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_last) begin
            rsp_ok <= chk_valid;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_two_of_five_sched.sv
// Bench for two_of_five_sched: a default build (CHK_LAT=1) driven by a behavioural
// serial checker, plus a CHK_LAT=3 build with hand-scheduled checker verdicts.
// Expected responses are queued at grant time and popped by independent monitors.
module tb_two_of_five_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req, req3;
  logic [19:0] code, code3;
  logic        chk_valid, chk3;
  logic [3:0]  gnt, gnt3;
  logic        ser_out, ser_sync, rsp_valid, rsp_ok, busy;
  logic        ser3, sync3, rsp_valid3, rsp_ok3, busy3;
  logic [1:0]  rsp_id, rsp_id3;
  logic [15:0] err_cnt, err_cnt3;

  two_of_five_sched #(.NREQ(4), .CHK_LAT(1)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .code(code), .gnt(gnt),
    .ser_out(ser_out), .ser_sync(ser_sync), .chk_valid(chk_valid),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ok(rsp_ok),
    .err_cnt(err_cnt), .busy(busy)
  );

  two_of_five_sched #(.NREQ(4), .CHK_LAT(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .req(req3), .code(code3), .gnt(gnt3),
    .ser_out(ser3), .ser_sync(sync3), .chk_valid(chk3),
    .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_ok(rsp_ok3),
    .err_cnt(err_cnt3), .busy(busy3)
  );

  typedef struct {
    int          id;
    bit          ok;
    logic [15:0] err;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [4:0]  ser_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] err_model = '0;
  logic [15:0] err3_model = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Response monitor, default build
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (q1.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = q1.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_ok", 32'(rsp_ok), 32'(e.ok));
          check("err_at_rsp", 32'(err_cnt), 32'(e.err));
          check("rsp_latency", 32'(cyc - e.gcyc), 32'(e.lat));
        end
      end
    end
  end

  // Response monitor, CHK_LAT=3 build
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid3) begin
        if (q3.size() == 0) begin
          fail_now("unexpected_rsp3");
        end else begin
          e = q3.pop_front();
          check("rsp3_id", 32'(rsp_id3), 32'(e.id));
          check("rsp3_ok", 32'(rsp_ok3), 32'(e.ok));
          check("rsp3_latency", 32'(cyc - e.gcyc), 32'(e.lat));
        end
      end
    end
  end

  // gnt must be one-hot-or-zero and only appear while idle
  initial begin
    forever begin
      @(negedge clk);
      if ((busy && gnt != 4'b0) || !$onehot0(gnt)) begin
        fail_now("gnt_illegal");
      end
    end
  end

  // Behavioural serial checker: collects five bits from the sync bit, verifies
  // them against the granted code, and answers in the cycle after bit 4.
  initial begin
    logic [4:0] bits;
    logic [4:0] expc;
    bit         abort;
    chk_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && ser_sync) begin
        bits    = '0;
        bits[0] = ser_out;
        abort   = 1'b0;
        for (int k = 1; k < 5; k++) begin
          @(negedge clk);
          if (!rstn) abort = 1'b1;
          bits[k] = ser_out;
          if (!abort) check("ser_sync_once", 32'(ser_sync), 32'd0);
        end
        if (ser_q.size() == 0) begin
          fail_now("unexpected_frame");
        end else begin
          expc = ser_q.pop_front();
          if (!abort) begin
            check("ser_bits", 32'(bits), 32'(expc));
            @(posedge clk);
            #1 chk_valid = ($countones(bits) == 2);
            @(posedge clk);
            #1 chk_valid = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_gnt(output logic [3:0] g, output int gc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0 && n < 200);
    g  = gnt;
    gc = cyc;
    if (gnt == 4'b0) fail_now("gnt_timeout");
  endtask

  task automatic expect_frame(input int id, input logic [4:0] c, input int gc);
    exp_t e;
    e.id   = id;
    e.ok   = ($countones(c) == 2);
    e.err  = err_model;
    e.gcyc = gc;
    e.lat  = 7;
    q1.push_back(e);
    ser_q.push_back(c);
    if (!e.ok && err_model != 16'hFFFF) err_model = err_model + 16'd1;
  endtask

  task automatic one_frame(input int id, input logic [4:0] c);
    logic [3:0] g, expg;
    int gc;
    @(posedge clk);
    #1;
    req[id] = 1'b1;
    code[5*id +: 5] = c;
    wait_gnt(g, gc);
    expg = '0;
    expg[id] = 1'b1;
    check("gnt_single", 32'(g), 32'(expg));
    expect_frame(id, c, gc);
    @(posedge clk);
    #1 req[id] = 1'b0;
  endtask

  // Hold a request mask and expect n grants in the packed order seq[4i+3:4i].
  task automatic held(input logic [3:0] mask, input int n, input logic [31:0] seq);
    logic [3:0] g, expg;
    int gc, prev, id;
    prev = 0;
    @(posedge clk);
    #1 req = mask;
    for (int i = 0; i < n; i++) begin
      wait_gnt(g, gc);
      expg = seq[4*i +: 4];
      check("gnt_seq", 32'(g), 32'(expg));
      check("busy_at_gnt", 32'(busy), 32'd0);
      if (i > 0) check("gnt_spacing", 32'(gc - prev), 32'd8);
      prev = gc;
      id = 0;
      for (int j = 0; j < 4; j++) if (g[j]) id = j;
      expect_frame(id, code[5*id +: 5], gc);
    end
    @(posedge clk);
    #1 req = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || busy3 || q1.size() != 0 || q3.size() != 0) && n < 300);
    if (n >= 300) fail_now("idle_timeout");
  endtask

  task automatic frame3(input logic [4:0] c, input logic [2:0] chk_pat, input bit exp_ok);
    logic [3:0] g;
    int n, gc;
    exp_t e;
    @(posedge clk);
    #1 req3 = 4'b0001;
    code3[4:0] = c;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt3 == 4'b0 && n < 200);
    g  = gnt3;
    gc = cyc;
    check("gnt3", 32'(g), 32'h1);
    e.id = 0; e.ok = exp_ok; e.err = err3_model; e.gcyc = gc; e.lat = 9;
    q3.push_back(e);
    if (!exp_ok) err3_model = err3_model + 16'd1;
    @(posedge clk);
    #1 req3 = '0;
    repeat (5) @(posedge clk);
    #1 chk3 = chk_pat[0];
    @(posedge clk);
    #1 chk3 = chk_pat[1];
    @(posedge clk);
    #1 chk3 = chk_pat[2];
    @(posedge clk);
    #1 chk3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    int gc;
    req = '0; code = '0; req3 = '0; code3 = '0; chk3 = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_ser_sync", 32'(ser_sync), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_ok", 32'(rsp_ok), 32'd0);
    req = '0;
    @(posedge clk);
    #1 rstn = 1'b1;

    // good code on requester 2
    one_frame(2, 5'b00101);
    // three-ones code on requester 1, three times
    one_frame(1, 5'b01110);
    one_frame(1, 5'b01110);
    one_frame(1, 5'b01110);
    wait_idle();
    check("err_after_3_bad", 32'(err_cnt), 32'd3);

    // move pointer to 0, then hold all four requests
    one_frame(3, 5'b10001);
    code = {5'b00110, 5'b11011, 5'b00000, 5'b10100};
    held(4'b1111, 5, 32'h0001_8421);
    wait_idle();
    check("err_after_rr", 32'(err_cnt), 32'(err_model));

    // pointer wrap: grant 3, then 0 and 3 both pending -> 0 first, then 3
    one_frame(3, 5'b01010);
    held(4'b1001, 2, 32'h0000_0081);
    wait_idle();

    // withdrawal: req[1] raised and dropped while busy; only req[2] gets granted
    one_frame(0, 5'b00011);
    @(posedge clk);
    #1 req[1] = 1'b1;
    code[9:5] = 5'b11111;
    repeat (2) @(posedge clk);
    #1 req[1] = 1'b0;
    req[2] = 1'b1;
    code[14:10] = 5'b01100;
    wait_gnt(g, gc);
    check("gnt_withdraw", 32'(g), 32'h4);
    expect_frame(2, 5'b01100, gc);
    @(posedge clk);
    #1 req = '0;
    wait_idle();

    // reset during SHIFT bit 2
    @(posedge clk);
    #1 req[0] = 1'b1;
    code[4:0] = 5'b00110;
    wait_gnt(g, gc);
    check("gnt_pre_reset", 32'(g), 32'h1);
    ser_q.push_back(5'b00110);
    @(posedge clk);
    #1 req = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    req = 4'b0100;
    #1;
    check("midrst_ser_out", 32'(ser_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    err_model = '0;
    err3_model = '0;
    repeat (3) @(negedge clk);
    req = '0;
    @(posedge clk);
    #1 rstn = 1'b1;
    code[9:5] = 5'b10010;
    code[19:15] = 5'b10010;
    held(4'b1010, 1, 32'h0000_0002);
    wait_idle();
    check("err_after_reset", 32'(err_cnt), 32'd0);

    // saturation: preload the counter to FFFE, then fail repeatedly
    @(negedge clk);
    force u_dut.err_cnt = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release u_dut.err_cnt;
    err_model = 16'hFFFE;
    @(negedge clk);
    check("err_preload", 32'(err_cnt), 32'h0000_FFFE);
    one_frame(2, 5'b00000);
    one_frame(2, 5'b00000);
    one_frame(3, 5'b11111);
    wait_idle();
    check("err_saturated", 32'(err_cnt), 32'h0000_FFFF);

    // CHK_LAT=3: glitch at t+6 ignored, verdict at t+8 latched
    frame3(5'b11000, 3'b101, 1'b1);
    frame3(5'b11100, 3'b011, 1'b0);
    wait_idle();
    check("err3_cnt", 32'(err_cnt3), 32'(err3_model));
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/two_of_five_sched.md
Name: two_of_five_sched

Overview:
- Shares one serial 2-of-5 code checker among NREQ requesters.
- Each requester presents a parallel 5-bit codeword. The block arbitrates round-robin and serializes the winner LSB-first onto the checker's serial input.
- It samples the checker's result at a fixed latency and returns a tagged pass/fail response, plus a saturating error counter.
- It sits between the codeword producers and the serial checker instance.

Parameters:
NREQ, 4, number of requesters (2..8)
CHK_LAT, 1, cycles from the cycle driving bit 4 to the cycle chk_valid is sampled (1..3)
IDW, $clog2(NREQ), requester-id width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-low
req  in  NREQ  per-requester request, level; held until gnt
code  in  NREQ*5  codeword of requester i at [5i+4:5i]
gnt  out  NREQ  one-hot acceptance pulse; code[i] sampled this cycle
ser_out  out  1  serial bit to checker, LSB first; 0 when not shifting
ser_sync  out  1  high in the cycle carrying bit 0 of a frame
chk_valid  in  1  checker result, 1 = exactly two ones
rsp_valid  out  1  one-cycle response pulse
rsp_id  out  IDW  requester id of the response
rsp_ok  out  1  latched chk_valid for the frame
err_cnt  out  16  count of rsp_ok=0 responses, saturates at 16'hFFFF
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = 0; err_cnt = 0; gnt forced 0 while rstn low.
- FSM states: IDLE, SHIFT, WAIT, RESP.
- IDLE:
  - If any req is high, grant the first requesting index at or after the rr pointer, scanning upward with wrap.
  - gnt is combinational from state/req/pointer.
  - On that edge: latch the codeword into a 5-bit shift register; latch id into rsp_id; set rr pointer = id+1 (wrap to 0 at NREQ); bit index = 0; go to SHIFT.
  - No req: stay in IDLE.
- SHIFT (5 cycles):
  - ser_out = shreg[0]; ser_sync = 1 only when bit index = 0; shift right each cycle.
  - After bit index 4, go to WAIT.
- WAIT (CHK_LAT cycles):
  - ser_out = 0.
  - In the final WAIT cycle, register chk_valid into rsp_ok; go to RESP.
- RESP (1 cycle):
  - rsp_valid = 1; rsp_id and rsp_ok stable.
  - If rsp_ok = 0, increment err_cnt unless it is at 16'hFFFF.
  - Go to IDLE.
- Timing:
  - Grant in cycle t → bits in t+1..t+5 → chk_valid sampled at t+5+CHK_LAT → rsp_valid at t+6+CHK_LAT.
  - Next grant no earlier than t+7+CHK_LAT (8-cycle frame period at default).
- rsp_id and rsp_ok hold their value until the next RESP; only rsp_valid pulses.
- req falling before gnt is a legal withdrawal: that requester is not granted.
- req and code changes outside IDLE are ignored.
- Requesters must drop req (or present a new code) after gnt. A still-high req is a new request, arbitrated fairly by the rr pointer.
- gnt is never asserted in SHIFT/WAIT/RESP, and at most one bit is high.
- chk_valid is ignored in every cycle other than the sample cycle.
- Reset mid-frame: frame abandoned; no rsp_valid; all state, pointer and err_cnt cleared.

Test Plan:
- req[2]=1, code[2]=5'b00101, bench checker model → gnt=4'b0100 at t; ser_out 1,0,1,0,0 over t+1..t+5 with ser_sync only at t+1; chk_valid=1 at t+6 → rsp_valid at t+7, rsp_id=2, rsp_ok=1, err_cnt=0.
- req[1]=1, code[1]=5'b01110 (three ones) → rsp_ok=0, rsp_id=1, err_cnt=1; repeat twice more → err_cnt=3.
- req=4'b1111 held continuously after each gnt → gnt sequence 0001,0010,0100,1000,0001, spaced 8 cycles; busy low exactly one cycle between frames.
- req[0] pulsed high with req[3]=1 from t after a grant to 3 → next grant goes to 0 (pointer wrap), then 3.
- rstn low during SHIFT bit 2 → ser_out, busy, gnt, rsp_valid = 0 immediately; no response; err_cnt=0; a fresh req after release is granted to the lowest index.
- CHK_LAT=3 build, code 5'b11000 → chk_valid sampled at t+8, rsp_valid at t+9, rsp_ok=1; a chk_valid glitch at t+6 has no effect.
- err_cnt forced to 16'hFFFE via back-to-back bad codes → reaches 16'hFFFF and stays there on further failures.
